// File: rtl/flex_counter_pkg.sv
// Shared constants for the multi-channel flex counter.
//   DEF_CNT_BITS : default counter width per channel
//   MAX_CH       : largest supported channel count
package flex_counter_pkg;
  localparam int DEF_CNT_BITS = 4;
  localparam int MAX_CH       = 16;
endpackage

// File: rtl/flex_counter_ch.sv
// Single flex-counter channel.
//   clk, n_rst     : clock, async active-low reset
//   clear, load    : synchronous clear / load strobe (clear wins)
//   load_val       : value taken on load
//   step           : count request for this edge (already cascade-qualified)
//   rollover_val   : terminal value; 0 disables counting
//   count_out      : registered count
//   rollover_flag  : registered, high while count_out == rollover_val != 0
//   wrap           : combinational, high when this edge wraps the count to 1
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    step,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    rv_zero;

  assign rv_zero = (rollover_val == '0);

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (step && !rv_zero) begin
      // >= rather than == so a terminal lowered under the count still wraps
      if (count_q >= rollover_val) begin
        count_d = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
    // flag follows the next-state count so both change on the same edge
    flag_d = !rv_zero && (count_d == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flex counters with optional cascade.
//   clk, n_rst     : clock, async active-low reset
//   clear, load,
//   count_enable   : per-channel controls (bit k -> channel k)
//   load_val,
//   rollover_val   : per-channel values, channel k at [k*NUM_CNT_BITS +: NUM_CNT_BITS]
//   count_out      : per-channel registered counts, same packing
//   rollover_flag  : per-channel terminal flags
//   all_rollover   : register of the AND of all rollover_flag bits
// With CASCADE=1, channel k>0 steps only on an edge where channel k-1 wraps
// (zero-cycle carry through the combinational wrap outputs).
module multi_flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_CH       = 4,
  parameter bit CASCADE      = 1'b0
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic                           all_rollover
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("multi_flex_counter: NUM_CH out of range");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic step;
    logic wrap;

    if (CASCADE && k > 0) begin : g_casc
      assign step = count_enable[k] & g_ch[k-1].wrap;
    end else begin : g_flat
      assign step = count_enable[k];
    end

    flex_counter_ch #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_ch (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear[k]),
      .load          (load[k]),
      .load_val      (load_val[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .step          (step),
      .rollover_val  (rollover_val[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_out     (count_out[k*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag (rollover_flag[k]),
      .wrap          (wrap)
    );
  end

  logic all_rollover_q, all_rollover_d;

  assign all_rollover_d = &rollover_flag;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) all_rollover_q <= 1'b0;
    else        all_rollover_q <= all_rollover_d;
  end

  assign all_rollover = all_rollover_q;

endmodule

// File: tb/tb_multi_flex_counter.sv
module tb_multi_flex_counter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;

  // default instance: 4 channels x 4 bits, no cascade
  logic [3:0]  clear, en, load;
  logic [15:0] lv, rv, co;
  logic [3:0]  rf;
  logic        ar;

  // cascade instance: 2 channels x 4 bits
  logic [1:0]  c_clear, c_en, c_load;
  logic [7:0]  c_lv, c_rv, c_co;
  logic [1:0]  c_rf;
  logic        c_ar;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_flex_counter dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(en), .load(load),
    .load_val(lv), .rollover_val(rv), .count_out(co), .rollover_flag(rf),
    .all_rollover(ar)
  );

  multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1'b1)) dut_c (
    .clk(clk), .n_rst(n_rst), .clear(c_clear), .count_enable(c_en), .load(c_load),
    .load_val(c_lv), .rollover_val(c_rv), .count_out(c_co), .rollover_flag(c_rf),
    .all_rollover(c_ar)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one edge, then sample 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic       en;
    logic [3:0] lv;
    logic [3:0] rv;
    logic [3:0] exp_cnt;
    logic       exp_flag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // channel 0 sequence, starting from reset (count 0)
    for (int i = 0; i < 7; i++)
      vecs.push_back('{"cnt_rv5", 1'b0, 1'b0, 1'b1, 4'd0, 4'd5,
                       4'((i % 5) + 1), (i == 4)});
    vecs.push_back('{"load9",        0, 1, 0, 4'd9,  4'd10, 4'd9,  0});
    vecs.push_back('{"rv_lowered",   0, 0, 1, 4'd0,  4'd4,  4'd1,  0});
    vecs.push_back('{"after_lower",  0, 0, 1, 4'd0,  4'd4,  4'd2,  0});
    vecs.push_back('{"clr_over_ld",  1, 1, 1, 4'd7,  4'd4,  4'd0,  0});
    vecs.push_back('{"ld_over_cnt",  0, 1, 1, 4'd7,  4'd10, 4'd7,  0});
    vecs.push_back('{"ld_at_term",   0, 1, 0, 4'd4,  4'd4,  4'd4,  1});
    vecs.push_back('{"wrap_after_ld",0, 0, 1, 4'd0,  4'd4,  4'd1,  0});
    vecs.push_back('{"clr_over_en",  1, 0, 1, 4'd0,  4'd4,  4'd0,  0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{"rv0_zero",   0, 0, 1, 4'd0,  4'd0,  4'd0,  0});
    vecs.push_back('{"ld3_rv0",      0, 1, 0, 4'd3,  4'd0,  4'd3,  0});
    vecs.push_back('{"rv0_hold",     0, 0, 1, 4'd0,  4'd0,  4'd3,  0});
    vecs.push_back('{"en_off_hold",  0, 0, 0, 4'd0,  4'd5,  4'd3,  0});
    vecs.push_back('{"wrap_eq",      0, 0, 1, 4'd0,  4'd3,  4'd1,  0});
    vecs.push_back('{"cnt_rv15",     0, 0, 1, 4'd0,  4'd15, 4'd2,  0});
    vecs.push_back('{"ld14",         0, 1, 0, 4'd14, 4'd15, 4'd14, 0});
    vecs.push_back('{"reach_max",    0, 0, 1, 4'd0,  4'd15, 4'd15, 1});
    vecs.push_back('{"wrap_max",     0, 0, 1, 4'd0,  4'd15, 4'd1,  0});

    clear = 4'b1110; en = '0; load = '0; lv = '0; rv = '0;
    c_clear = '0; c_en = '0; c_load = '0; c_lv = '0; c_rv = '0;

    // reset state
    #3;
    chk("rst_count", 32'(co), 32'h0);
    chk("rst_flag",  32'(rf), 32'h0);
    chk("rst_all",   32'(ar), 32'h0);
    chk("rst_c_count", 32'(c_co), 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      clear[0] = vecs[i].clr;
      load[0]  = vecs[i].ld;
      en[0]    = vecs[i].en;
      lv[3:0]  = vecs[i].lv;
      rv[3:0]  = vecs[i].rv;
      tick();
      chk({vecs[i].name, "_cnt"},  32'(co[3:0]), 32'(vecs[i].exp_cnt));
      chk({vecs[i].name, "_flag"}, 32'(rf[0]),   32'(vecs[i].exp_flag));
    end
    chk("all_ro_idle", 32'(ar), 32'h0);

    // async reset in mid-cycle at count 4; ch0 currently 1
    clear[0] = 0; load[0] = 0; en[0] = 1; rv[3:0] = 4'd5;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_cnt", 32'(co[3:0]), 32'd4);
    en[0] = 0;
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_cnt",  32'(co), 32'h0);
    chk("async_rst_flag", 32'(rf), 32'h0);
    #1 n_rst = 1'b1;
    en[0] = 1;
    tick();
    chk("post_rst_step", 32'(co[3:0]), 32'd1);

    // all channels independent, rollover_val 1 each
    clear = '0; en = 4'b1111; rv = 16'h1111;
    tick();
    chk("all_ch_cnt",  32'(co), 32'h1111);
    chk("all_ch_flag", 32'(rf), 32'hf);
    en = '0;
    tick();
    chk("all_ro_set", 32'(ar), 32'h1);
    clear = 4'b0100;
    tick();
    chk("clr_ch2_cnt",  32'(co), 32'h1011);
    chk("clr_ch2_flag", 32'(rf), 32'hb);
    clear = '0;
    tick();
    chk("all_ro_clr", 32'(ar), 32'h0);

    // cascade: rv0=3, rv1=2, ch1 steps only on ch0 wrap edges
    c_rv = 8'h23; c_en = 2'b11;
    begin
      logic [7:0] exp_c [9];
      exp_c = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
      for (int i = 0; i < 9; i++) begin
        tick();
        chk($sformatf("casc_step%0d", i + 1), 32'(c_co), 32'(exp_c[i]));
      end
    end
    chk("casc_flags", 32'(c_rf), 32'h3);
    c_en = 2'b00;
    tick();
    chk("casc_hold", 32'(c_co), 32'h23);
    chk("casc_all",  32'(c_ar), 32'h1);

    // load on ch0 at its terminal suppresses the carry
    c_en = 2'b11; c_load = 2'b01; c_lv = 8'h03;
    tick();
    chk("casc_ld_nocarry", 32'(c_co), 32'h23);
    c_load = '0;
    tick();
    chk("casc_double_wrap", 32'(c_co), 32'h11);

    // ch1 enable low blocks the carry
    c_en = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    chk("casc_en1_off", 32'(c_co), 32'h11);

    // clear on ch0 at its terminal suppresses the carry
    c_en = 2'b11;
    tick(); tick();
    chk("casc_pre_clr", 32'(c_co), 32'h13);
    c_clear = 2'b01;
    tick();
    chk("casc_clr_nocarry", 32'(c_co), 32'h10);
    c_clear = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
